// File: rtl/ifetch_stage_pkg.sv
// Purpose: shared constants for the instruction-fetch stage (FSM encoding, reset vector, pc step).
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ifetch_stage_pkg;

    // Two-bit FSM encoding, kept as plain constants so legacy tools can read it.
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_FETCH   = 2'd1;
    localparam logic [1:0] ST_ISSUE   = 2'd2;
    localparam logic [1:0] ST_DISCARD = 2'd3;

    localparam logic [31:0] RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;

    // Force an address onto a word boundary; the low two bits carry no meaning.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/ifetch_stage_pc_reg.sv
// Purpose: program-counter register with next-pc select (hold / +PC_STEP / branch target).
// Latency: new pc visible one cycle after load_seq or load_br.
// Backpressure: none; holds its value whenever neither load is asserted.
//
// Ports: clk, rst (sync, active-high), load_seq (advance by PC_STEP),
//        load_br (take br_target, word-aligned; wins over load_seq), br_target, pc.
module pc_reg
    import ifetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load_seq,
    input  logic        load_br,
    input  logic [31:0] br_target,
    output logic [31:0] pc
);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_VEC;
        end else if (load_br) begin
            pc <= align_word(br_target);
        end else if (load_seq) begin
            // 32-bit add wraps naturally: 0xFFFFFFFC + 4 -> 0x00000000.
            pc <= pc + PC_STEP;
        end
    end

endmodule

// File: rtl/ifetch_stage.sv
// Purpose: single-outstanding instruction fetch FSM feeding a registered instruction to decode.
// Latency: instruction presented one cycle after imem_ack; next request one cycle after consume.
// Backpressure: stall holds the presented instruction and suppresses new requests.
//
// Ports: clk, rst (sync, active-high); imem_req/imem_addr/imem_ack/imem_rdata memory read port;
//        branch_taken/branch_target redirect; stall from decode; instr_valid, instr, OP, funct,
//        pc_out towards decode.
module ifetch_stage
    import ifetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        stall,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [5:0]  OP,
    output logic [5:0]  funct,
    output logic [31:0] pc_out
);

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [31:0] pc;
    logic [31:0] hold_addr;   // address of a request whose data will be thrown away
    logic        in_fetch;
    logic        in_issue;
    logic        in_discard;
    logic        accept;      // FETCH completes with data that is kept
    logic        release_ins; // presented instruction leaves (consumed or killed)
    logic        load_seq;
    logic        load_br;

    assign in_fetch    = (state == ST_FETCH);
    assign in_issue    = (state == ST_ISSUE);
    assign in_discard  = (state == ST_DISCARD);
    assign accept      = in_fetch && imem_ack && !branch_taken;
    assign release_ins = in_issue && (branch_taken || !stall);

    // Redirects are honoured everywhere except IDLE; pc advances only on a kept fetch.
    assign load_br  = branch_taken && (state != ST_IDLE);
    assign load_seq = accept;

    pc_reg u_pc_reg (
        .clk       (clk),
        .rst       (rst),
        .load_seq  (load_seq),
        .load_br   (load_br),
        .br_target (branch_target),
        .pc        (pc)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    state_nxt = ST_FETCH;
            ST_FETCH: begin
                if (imem_ack) begin
                    // Branch with ack in the same cycle drops the data and refetches at once.
                    state_nxt = branch_taken ? ST_FETCH : ST_ISSUE;
                end else if (branch_taken) begin
                    // Request already on the bus: must still wait for its ack.
                    state_nxt = ST_DISCARD;
                end
            end
            ST_ISSUE: begin
                if (branch_taken || !stall) begin
                    state_nxt = ST_FETCH;
                end
            end
            ST_DISCARD: begin
                if (imem_ack) begin
                    state_nxt = ST_FETCH;
                end
            end
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            instr       <= 32'h0;
            pc_out      <= 32'h0;
            instr_valid <= 1'b0;
            hold_addr   <= RESET_VEC;
        end else begin
            state <= state_nxt;
            if (accept) begin
                instr       <= imem_rdata;
                pc_out      <= pc;
                instr_valid <= 1'b1;
            end else if (release_ins) begin
                instr_valid <= 1'b0;
            end
            // pc is about to be overwritten by the target; keep the bus address stable.
            if (in_fetch && !imem_ack && branch_taken) begin
                hold_addr <= pc;
            end
        end
    end

    assign imem_req  = in_fetch || in_discard;
    assign imem_addr = in_discard ? hold_addr : pc;
    assign OP        = instr[31:26];
    assign funct     = instr[5:0];

endmodule

// File: tb/tb_ifetch_stage.sv
module tb_ifetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        stall;
    logic        instr_valid;
    logic [31:0] instr;
    logic [5:0]  OP;
    logic [5:0]  funct;
    logic [31:0] pc_out;

    always #5 clk = ~clk;

    ifetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .stall         (stall),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .OP            (OP),
        .funct         (funct),
        .pc_out        (pc_out)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
        int          due;
    } iss_t;

    iss_t        iss_q[$];   // instructions expected to be presented, in order
    logic [31:0] req_q[$];   // addresses expected for each fresh memory request
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    // Reference model: abstract view of what the fetch unit owes decode.
    logic        m_idle, m_held, m_doomed;
    logic [31:0] m_held_pc, m_cur, m_next;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
    endtask

    task automatic push_req(input logic [31:0] a);
        req_q.push_back(a & ~32'h3);
        m_cur = a & ~32'h3;
    endtask

    // Apply one cycle of inputs and advance the model by the fetch rules.
    task automatic do_cycle(input logic a, input logic [31:0] d, input logic b,
                            input logic [31:0] t, input logic s);
        imem_ack      = a;
        imem_rdata    = d;
        branch_taken  = b;
        branch_target = t;
        stall         = s;
        if (m_idle) begin
            m_idle = 1'b0;           // ack and branch are ignored before the first fetch
        end else if (m_held) begin
            if (b) push_req(t);
            else if (!s) push_req(m_held_pc + 32'd4);
            if (b || !s) m_held = 1'b0;
        end else if (m_doomed) begin
            if (b) m_next = t & ~32'h3;
            if (a) begin
                push_req(m_next);
                m_doomed = 1'b0;
            end
        end else begin
            if (a && b) begin
                push_req(t);
            end else if (a) begin
                iss_q.push_back('{pc: m_cur, word: d, due: cyc + 1});
                m_held    = 1'b1;
                m_held_pc = m_cur;
            end else if (b) begin
                m_doomed = 1'b1;
                m_next   = t & ~32'h3;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic a);
        rst          = 1'b1;
        imem_ack     = a;
        imem_rdata   = $urandom;
        branch_taken = 1'b0;
        stall        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        req_q.delete();
        iss_q.delete();
        push_req(32'h0);
        m_idle   = 1'b1;
        m_held   = 1'b0;
        m_doomed = 1'b0;
        m_next   = 32'h0;
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    logic        prev_rst = 1'b0, prev_req = 1'b0, prev_ack = 1'b0;
    logic        prev_valid = 1'b0, prev_stall = 1'b0, prev_br = 1'b0;
    logic [31:0] prev_addr = '0, prev_instr = '0, prev_pcout = '0;

    always @(negedge clk) begin
        if (prev_rst) begin
            chk("rst_imem_req", 32'(imem_req), 32'h0);
            chk("rst_instr_valid", 32'(instr_valid), 32'h0);
            chk("rst_instr", instr, 32'h0);
            chk("rst_pc_out", pc_out, 32'h0);
        end else begin
            if (imem_req && (!prev_req || prev_ack)) begin
                if (req_q.size() == 0) flag_fail("unexpected_request");
                else chk("req_addr", imem_addr, req_q.pop_front());
            end else if (imem_req && prev_req) begin
                chk("addr_stable", imem_addr, prev_addr);
            end
            if (instr_valid) begin
                chk("req_while_valid", 32'(imem_req), 32'h0);
                if (prev_valid) begin
                    chk("valid_only_if_stalled", 32'(prev_stall && !prev_br), 32'h1);
                    chk("hold_instr", instr, prev_instr);
                    chk("hold_pc_out", pc_out, prev_pcout);
                end else if (iss_q.size() == 0) begin
                    flag_fail("unexpected_issue");
                end else begin
                    iss_t e;
                    e = iss_q.pop_front();
                    chk("issue_instr", instr, e.word);
                    chk("issue_pc_out", pc_out, e.pc);
                    chk("issue_OP", 32'(OP), 32'(e.word[31:26]));
                    chk("issue_funct", 32'(funct), 32'(e.word[5:0]));
                    chk("issue_latency", 32'(cyc), 32'(e.due));
                end
            end
        end
        prev_rst   = rst;
        prev_req   = imem_req;
        prev_ack   = imem_ack;
        prev_valid = instr_valid;
        prev_stall = stall;
        prev_br    = branch_taken;
        prev_addr  = imem_addr;
        prev_instr = instr;
        prev_pcout = pc_out;
    end

    initial begin
        logic [31:0] tgt;
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
        branch_taken = 1'b0; branch_target = '0; stall = 1'b0;
        do_reset(1'b0);

        // Zero-wait memory: addresses 0,4,8; first word is an R-type add.
        for (int k = 0; k < 7; k++)
            do_cycle(imem_req, (k == 1) ? 32'h012A_4020 : $urandom, 1'b0, 32'h0, 1'b0);

        // Fetch at 0xC, hold it for three stalled cycles, then consume -> 0x10.
        do_cycle(1'b1, $urandom, 1'b0, 32'h0, 1'b0);
        repeat (3) do_cycle(1'b0, $urandom, 1'b0, 32'h0, 1'b1);
        do_cycle(1'b0, $urandom, 1'b0, 32'h0, 1'b0);

        // Fetch 0x10, then branch to 0x103 while stalled in issue -> refetch at 0x100.
        do_cycle(1'b1, $urandom, 1'b0, 32'h0, 1'b0);
        do_cycle(1'b0, $urandom, 1'b1, 32'h0000_0103, 1'b1);

        // Branch to 0x40 during fetch of 0x100; ack arrives three cycles later and is dropped.
        do_cycle(1'b0, $urandom, 1'b1, 32'h0000_0040, 1'b0);
        repeat (2) do_cycle(1'b0, $urandom, 1'b0, 32'h0, 1'b0);
        do_cycle(1'b1, $urandom, 1'b0, 32'h0, 1'b0);

        // Fetch 0x40, redirect to the top word, fetch and consume it -> wrap to 0x0.
        do_cycle(1'b1, $urandom, 1'b0, 32'h0, 1'b0);
        do_cycle(1'b0, $urandom, 1'b1, 32'hFFFF_FFFF, 1'b0);
        do_cycle(1'b1, $urandom, 1'b0, 32'h0, 1'b0);
        do_cycle(1'b0, $urandom, 1'b0, 32'h0, 1'b0);

        // Reset while a doomed request is outstanding; ack and branch in IDLE are ignored.
        do_cycle(1'b0, $urandom, 1'b1, 32'h0000_0200, 1'b0);
        do_reset(1'b1);
        do_cycle(1'b1, $urandom, 1'b1, 32'h0000_0300, 1'b0);
        repeat (4) do_cycle(imem_req, $urandom, 1'b0, 32'h0, 1'b0);

        // Random traffic: variable ack delay, stalls, redirects (some near the wrap point).
        repeat (4000) begin
            tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : $urandom;
            do_cycle(imem_req && ($urandom_range(0, 1) == 1), $urandom,
                     ($urandom_range(0, 7) == 0), tgt, ($urandom_range(0, 2) == 0));
        end

        repeat (4) do_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("issue_queue_drained", 32'(iss_q.size()), 32'h0);
        chk("request_queue_drained", 32'(req_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
